// File: rtl/jtopll_wrq_if.sv
// CPU-side strobe bus and MMR-side replay/status signals for the OPLL write queue.
`timescale 1ns/1ps
interface jtopll_wrq_if #(parameter int DEPTH = 8);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          cen;
    logic          cs_n;
    logic          wr_n;
    logic          cpu_addr;
    logic [7:0]    cpu_din;
    logic          write;
    logic          addr;
    logic [7:0]    dout;
    logic          busy;
    logic          full;
    logic          ovf;
    logic [LW-1:0] level;

    modport slave (
        input  cen, cs_n, wr_n, cpu_addr, cpu_din,
        output write, addr, dout, busy, full, ovf, level
    );

    modport master (
        output cen, cs_n, wr_n, cpu_addr, cpu_din,
        input  write, addr, dout, busy, full, ovf, level
    );
endinterface

// File: rtl/jtopll_wrq.sv
// Buffers CPU writes to the OPLL and replays them to the MMR, spaced by
// the chip's address/data access times counted in cen ticks.
`timescale 1ns/1ps
module jtopll_wrq #(
    parameter int DEPTH     = 8,
    parameter int ADDR_WAIT = 12,
    parameter int DATA_WAIT = 84
) (
    input  logic         clk,
    input  logic         rst,
    jtopll_wrq_if.slave  bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = PW + 1;
    localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int CW   = $clog2(MAXW + 1);

    typedef struct packed {
        logic       addr;
        logic [7:0] data;
    } entry_t;

    typedef enum logic {IDLE, WAIT} state_t;

    // capture and FIFO state
    logic          wr_l_q;
    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q;

    // pacer state
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          write_q;
    logic          addr_q;
    logic [7:0]    dout_q;

    logic   push, pop, accept, empty, is_full;
    entry_t head;

    assign empty   = (level_q == '0);
    assign is_full = (level_q == LW'(DEPTH));
    assign push    = wr_l_q & ~bus.wr_n & ~bus.cs_n;
    assign pop     = (state_q == IDLE) & ~empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign accept  = push & (~is_full | pop);
    assign head    = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (accept)
            wptr_d = wptr_q + 1'b1;
        if (pop)
            rptr_d = rptr_q + 1'b1;
        if (accept && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !accept)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_l_q  <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_l_q  <= bus.wr_n;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            if (push && !accept)
                ovf_q <= 1'b1;
        end
    end

    // storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk) begin
        if (!rst && accept)
            mem_q[wptr_q] <= '{addr: bus.cpu_addr, data: bus.cpu_din};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        write_q <= 1'b1;
                        addr_q  <= head.addr;
                        dout_q  <= head.data;
                        cnt_q   <= head.addr ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.cen) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1))
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.write = write_q;
    assign bus.addr  = addr_q;
    assign bus.dout  = dout_q;
    assign bus.busy  = ~empty | (state_q != IDLE);
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.level = level_q;
endmodule

// File: tb/tb_jtopll_wrq.sv
// Scoreboard bench for jtopll_wrq: stimulus queues expected replays, a
// negedge monitor pops and compares on every write pulse.
`timescale 1ns/1ps
module tb_jtopll_wrq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtopll_wrq_if #(.DEPTH(8)) ifc ();
    jtopll_wrq #(.DEPTH(8), .ADDR_WAIT(12), .DATA_WAIT(84)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] exp_q[$];
    int cyc = 0, cen_cnt = 0, pulses = 0, last_cyc = 0, last_cen = 0;
    logic prev_write = 1'b0;
    bit cen_auto = 1'b0;
    int div = 0;

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.cen) cen_cnt <= cen_cnt + 1;
    end

    // cen every 4th clk while cen_auto, otherwise driven by the stimulus
    initial forever begin
        @(negedge clk);
        if (cen_auto) begin
            ifc.cen = (div == 3);
            div = (div + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (ifc.write) begin
            pulses++;
            last_cyc = cyc;
            last_cen = cen_cnt;
            check("pulse_one_clk", int'(prev_write), 0);
            check("pulse_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("replay_addr_data", int'({ifc.addr, ifc.dout}), int'(e));
            end
        end
        prev_write = ifc.write;
    end

    task automatic nclk(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic strobe(logic a, logic [7:0] d, bit expect_push = 1'b1);
        ifc.cs_n = 1'b0; ifc.wr_n = 1'b0; ifc.cpu_addr = a; ifc.cpu_din = d;
        if (expect_push) exp_q.push_back({a, d});
        nclk();
        ifc.wr_n = 1'b1; ifc.cs_n = 1'b1;
        nclk();
    endtask

    task automatic wait_pulses(int n, int budget, string name);
        int t = 0;
        while (pulses < n && t < budget) begin
            nclk();
            t++;
        end
        check(name, pulses, n);
    endtask

    task automatic wait_idle(int budget, string name);
        int t = 0;
        while (ifc.busy && t < budget) begin
            nclk();
            t++;
        end
        check(name, int'(ifc.busy), 0);
    endtask

    task automatic do_reset();
        cen_auto = 1'b0;
        ifc.cen = 1'b0;
        rst = 1'b1;
        nclk();
        rst = 1'b0;
        exp_q.delete();
        nclk();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, p0, p1, c0, cy0, gap;
        ifc.cen = 1'b0; ifc.cs_n = 1'b1; ifc.wr_n = 1'b1;
        ifc.cpu_addr = 1'b0; ifc.cpu_din = 8'h00;
        rst = 1'b1;
        nclk(3);
        check("rst_write", int'(ifc.write), 0);
        check("rst_addr",  int'(ifc.addr), 0);
        check("rst_dout",  int'(ifc.dout), 0);
        check("rst_busy",  int'(ifc.busy), 0);
        check("rst_full",  int'(ifc.full), 0);
        check("rst_ovf",   int'(ifc.ovf), 0);
        check("rst_level", int'(ifc.level), 0);
        rst = 1'b0;
        nclk();

        // single address write, latency and busy duration
        cen_auto = 1'b1;
        s = cyc; p0 = pulses;
        ifc.cs_n = 1'b0; ifc.wr_n = 1'b0; ifc.cpu_addr = 1'b0; ifc.cpu_din = 8'h10;
        exp_q.push_back(9'h010);
        nclk();
        check("level_after_push", int'(ifc.level), 1);
        check("write_not_yet", int'(ifc.write), 0);
        ifc.wr_n = 1'b1; ifc.cs_n = 1'b1;
        wait_pulses(p0 + 1, 10, "single_pulse");
        check("replay_latency", last_cyc - s, 2);
        c0 = last_cen;
        wait_idle(200, "single_idle");
        check("busy_ticks_addr", cen_cnt - c0, 12);

        // address then data, back to back
        p0 = pulses;
        strobe(1'b0, 8'h10);
        strobe(1'b1, 8'h55);
        wait_pulses(p0 + 1, 10, "ad_first");
        c0 = last_cen; cy0 = last_cyc;
        wait_pulses(p0 + 2, 200, "ad_second");
        check("gap_ticks_addr", last_cen - c0, 12);
        gap = last_cyc - cy0;
        check("gap_clk_range", int'(gap >= 46 && gap <= 49), 1);
        c0 = last_cen;
        wait_idle(600, "ad_idle");
        check("busy_ticks_data", cen_cnt - c0, 84);

        // overflow with cen stalled
        do_reset();
        p0 = pulses;
        for (int i = 0; i < 10; i++)
            strobe(1'b1, 8'hA0 + 8'(i), i < 9);
        check("ovf_level", int'(ifc.level), 8);
        check("ovf_full", int'(ifc.full), 1);
        check("ovf_flag", int'(ifc.ovf), 1);
        check("ovf_first_out", pulses - p0, 1);
        cen_auto = 1'b1;
        wait_pulses(p0 + 9, 9 * 400, "ovf_drain");
        wait_idle(400, "ovf_idle");
        check("ovf_pulse_count", pulses - p0, 9);
        check("ovf_sb_empty", exp_q.size(), 0);
        check("ovf_sticky", int'(ifc.ovf), 1);

        // push coinciding with pop while full
        do_reset();
        check("ovf_cleared", int'(ifc.ovf), 0);
        p0 = pulses;
        for (int i = 0; i < 9; i++)
            strobe(1'b1, 8'h30 + 8'(i));
        check("pp_full", int'(ifc.full), 1);
        ifc.cen = 1'b1;
        nclk(84);
        ifc.cen = 1'b0;
        ifc.cs_n = 1'b0; ifc.wr_n = 1'b0; ifc.cpu_addr = 1'b0; ifc.cpu_din = 8'h77;
        exp_q.push_back(9'h077);
        nclk();
        ifc.wr_n = 1'b1; ifc.cs_n = 1'b1;
        check("pp_write", int'(ifc.write), 1);
        check("pp_level", int'(ifc.level), 8);
        check("pp_ovf", int'(ifc.ovf), 0);
        cen_auto = 1'b1;
        wait_pulses(p0 + 10, 10 * 400, "pp_drain");
        wait_idle(400, "pp_idle");
        check("pp_sb_empty", exp_q.size(), 0);

        // reset mid-WAIT with entries queued
        p0 = pulses;
        for (int i = 0; i < 4; i++)
            strobe(1'b1, 8'hE0 + 8'(i));
        nclk(10);
        check("rst_mid_level", int'(ifc.level), 3);
        ifc.cs_n = 1'b0; ifc.wr_n = 1'b0; ifc.cpu_din = 8'hEE;
        rst = 1'b1;
        nclk();
        check("rst_mid_level0", int'(ifc.level), 0);
        check("rst_mid_busy", int'(ifc.busy), 0);
        check("rst_mid_write", int'(ifc.write), 0);
        rst = 1'b0;
        ifc.wr_n = 1'b1; ifc.cs_n = 1'b1;
        exp_q.delete();
        p1 = pulses;
        nclk(400);
        check("rst_mid_no_pulse", pulses - p1, 0);
        check("rst_mid_first_only", p1 - p0, 1);

        // held strobe pushes once; deselected strobe pushes nothing
        p0 = pulses;
        ifc.cs_n = 1'b0; ifc.wr_n = 1'b0; ifc.cpu_addr = 1'b1; ifc.cpu_din = 8'hC3;
        exp_q.push_back(9'h1C3);
        nclk(20);
        ifc.wr_n = 1'b1; ifc.cs_n = 1'b1;
        nclk();
        wait_idle(600, "held_idle");
        check("held_one_push", pulses - p0, 1);
        ifc.cs_n = 1'b1; ifc.wr_n = 1'b0; ifc.cpu_din = 8'h5A;
        nclk();
        check("cs_off_level", int'(ifc.level), 0);
        check("cs_off_busy", int'(ifc.busy), 0);
        ifc.wr_n = 1'b1;
        nclk(5);
        check("cs_off_no_pulse", pulses - p0, 1);
        check("final_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
